// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the WB stage (A) and the
// mult/div unit (B): A has priority, and a wait counter forces B ahead after STARVE_MAX cycles.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_regwrite,
    output logic [ADDR_W-1:0] rf_writereg,
    output logic [DATA_W-1:0] rf_writedata,
    output logic              prio_b
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             a_xfer;
    logic             b_xfer;

    assign a_xfer = a_valid & a_ready;
    assign b_xfer = b_valid & b_ready;
    assign prio_b = (state == PRIO_B);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PRIO_A;
        end else begin
            state <= state_next;
        end
    end

    // Next state: B is promoted on the edge where its wait count reaches STARVE_MAX
    always_comb begin
        state_next = state;
        case (state)
            PRIO_A: if (cnt_next == CNT_W'(STARVE_MAX)) state_next = PRIO_B;
            PRIO_B: if (b_xfer || !b_valid) state_next = PRIO_A;
            default: state_next = PRIO_A;
        endcase
    end

    // Grant outputs; the two readies are mutually exclusive in both states
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state)
            PRIO_A: begin
                a_ready = a_valid & ~hold;
                b_ready = b_valid & ~a_valid & ~hold;
            end
            PRIO_B: begin
                b_ready = b_valid & ~hold;
                a_ready = a_valid & ~b_valid & ~hold;
            end
            default: begin
                a_ready = 1'b0;
                b_ready = 1'b0;
            end
        endcase
    end

    // Wait counter; leaving PRIO_B always coincides with a B transfer or b_valid low
    always_comb begin
        cnt_next = cnt;
        if (b_xfer || !b_valid) begin
            cnt_next = '0;
        end else if (!hold && state == PRIO_A && cnt != CNT_W'(STARVE_MAX)) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Registered write port; writes to register 0 are swallowed without touching reg/data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_regwrite  <= 1'b0;
            rf_writereg  <= '0;
            rf_writedata <= '0;
        end else begin
            rf_regwrite <= 1'b0;
            if (a_xfer && a_reg != '0) begin
                rf_regwrite  <= 1'b1;
                rf_writereg  <= a_reg;
                rf_writedata <= a_data;
            end else if (b_xfer && b_reg != '0) begin
                rf_regwrite  <= 1'b1;
                rf_writereg  <= b_reg;
                rf_writedata <= b_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (default parameters,
// STARVE_MAX=4), plus hand-written async reset / starvation sequences.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        b_ready;
    logic        rf_regwrite;
    logic [4:0]  rf_writereg;
    logic [31:0] rf_writedata;
    logic        prio_b;

    int tests = 0;
    int fails = 0;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .a_valid      (a_valid),
        .a_reg        (a_reg),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_reg        (b_reg),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .rf_regwrite  (rf_regwrite),
        .rf_writereg  (rf_writereg),
        .rf_writedata (rf_writedata),
        .prio_b       (prio_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        hold;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic        e_ar;
        logic        e_br;
        logic        e_pb;
        logic        e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(int h, int av, int ar, int ad, int bv, int br, int bd,
                                int ear, int ebr, int epb, int erw, int ewr, int ewd);
        vec_t v;
        v.hold = 1'(h);   v.av = 1'(av);   v.ar = 5'(ar);   v.ad = 32'(ad);
        v.bv = 1'(bv);    v.br = 5'(br);   v.bd = 32'(bd);
        v.e_ar = 1'(ear); v.e_br = 1'(ebr); v.e_pb = 1'(epb); v.e_rw = 1'(erw);
        v.e_wr = 5'(ewr); v.e_wd = 32'(ewd);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        hold = 1'b0; a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
    endtask

    // Drive A and B every cycle (fresh A request each cycle) until prio_b rises.
    // Returns at mid-cycle of the PRIO_B cycle, n = number of cycles before it.
    task automatic run_to_prio(output int n);
        n = 0;
        hold = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        b_reg = 5'd20; b_data = 32'h0000C0DE;
        while (n < 10) begin
            a_reg = 5'(16 + n);
            a_data = 32'(32'hF000 + n);
            #3;
            if (prio_b) break;
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        idle_inputs();
        #2;
        chk("reset.regwrite", 32'(rf_regwrite), 32'd0);
        chk("reset.writereg", 32'(rf_writereg), 32'd0);
        chk("reset.writedata", rf_writedata, 32'd0);
        chk("reset.prio_b", 32'(prio_b), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // hold, A(v,reg,data), B(v,reg,data) | a_ready, b_ready, prio_b, regwrite, writereg, writedata
        vt.push_back(mk(0, 0, 0, 0,          0, 0, 0,      0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 5, 'hDEADBEEF, 0, 0, 0,      1, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0,          0, 0, 0,      0, 0, 0, 1, 5, 'hDEADBEEF));
        vt.push_back(mk(0, 0, 0, 0,          0, 0, 0,      0, 0, 0, 0, 5, 'hDEADBEEF));
        vt.push_back(mk(0, 0, 0, 0,          1, 0, 'h1234, 0, 1, 0, 0, 5, 'hDEADBEEF));
        vt.push_back(mk(0, 0, 0, 0,          0, 0, 0,      0, 0, 0, 0, 5, 'hDEADBEEF));
        vt.push_back(mk(0, 0, 0, 0,          1, 7, 'hB7,   0, 1, 0, 0, 5, 'hDEADBEEF));
        vt.push_back(mk(0, 0, 0, 0,          0, 0, 0,      0, 0, 0, 1, 7, 'hB7));
        // starvation: four A grants, then B forced ahead
        vt.push_back(mk(0, 1, 1, 'hA1,       1, 9, 'hB9,   1, 0, 0, 0, 7, 'hB7));
        vt.push_back(mk(0, 1, 2, 'hA2,       1, 9, 'hB9,   1, 0, 0, 1, 1, 'hA1));
        vt.push_back(mk(0, 1, 3, 'hA3,       1, 9, 'hB9,   1, 0, 0, 1, 2, 'hA2));
        vt.push_back(mk(0, 1, 4, 'hA4,       1, 9, 'hB9,   1, 0, 0, 1, 3, 'hA3));
        vt.push_back(mk(0, 1, 5, 'hA5,       1, 9, 'hB9,   0, 1, 1, 1, 4, 'hA4));
        vt.push_back(mk(0, 1, 5, 'hA5,       0, 0, 0,      1, 0, 0, 1, 9, 'hB9));
        vt.push_back(mk(0, 0, 0, 0,          0, 0, 0,      0, 0, 0, 1, 5, 'hA5));
        // hold: counter frozen at 1, registered write still appears
        vt.push_back(mk(0, 1, 6, 'hA6,       1, 10, 'hBA,  1, 0, 0, 0, 5, 'hA5));
        vt.push_back(mk(1, 1, 8, 'hA8,       1, 10, 'hBA,  0, 0, 0, 1, 6, 'hA6));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(1, 1, 8, 'hA8,   1, 10, 'hBA,  0, 0, 0, 0, 6, 'hA6));
        vt.push_back(mk(0, 1, 8, 'hA8,       1, 10, 'hBA,  1, 0, 0, 0, 6, 'hA6));
        vt.push_back(mk(0, 1, 11, 'hAB,      1, 10, 'hBA,  1, 0, 0, 1, 8, 'hA8));
        vt.push_back(mk(0, 1, 12, 'hAC,      1, 10, 'hBA,  1, 0, 0, 1, 11, 'hAB));
        vt.push_back(mk(0, 1, 13, 'hAD,      1, 10, 'hBA,  0, 1, 1, 1, 12, 'hAC));
        vt.push_back(mk(0, 1, 13, 'hAD,      0, 0, 0,      1, 0, 0, 1, 10, 'hBA));
        vt.push_back(mk(0, 0, 0, 0,          0, 0, 0,      0, 0, 0, 1, 13, 'hAD));

        foreach (vt[i]) begin
            hold = vt[i].hold;
            a_valid = vt[i].av; a_reg = vt[i].ar; a_data = vt[i].ad;
            b_valid = vt[i].bv; b_reg = vt[i].br; b_data = vt[i].bd;
            #3;
            chk($sformatf("v%0d.a_ready", i), 32'(a_ready), 32'(vt[i].e_ar));
            chk($sformatf("v%0d.b_ready", i), 32'(b_ready), 32'(vt[i].e_br));
            chk($sformatf("v%0d.prio_b", i), 32'(prio_b), 32'(vt[i].e_pb));
            chk($sformatf("v%0d.regwrite", i), 32'(rf_regwrite), 32'(vt[i].e_rw));
            chk($sformatf("v%0d.writereg", i), 32'(rf_writereg), 32'(vt[i].e_wr));
            chk($sformatf("v%0d.writedata", i), rf_writedata, vt[i].e_wd);
            @(posedge clk); #1;
        end

        // Async reset while in PRIO_B with B pending and an A write registered
        run_to_prio(n);
        chk("seq1.cycles_to_prio", 32'(n), 32'd4);
        chk("seq1.b_ready", 32'(b_ready), 32'd1);
        chk("seq1.regwrite_pre", 32'(rf_regwrite), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst.prio_b", 32'(prio_b), 32'd0);
        chk("rst.regwrite", 32'(rf_regwrite), 32'd0);
        chk("rst.writereg", 32'(rf_writereg), 32'd0);
        chk("rst.writedata", rf_writedata, 32'd0);
        chk("rst.a_ready", 32'(a_ready), 32'd1);
        chk("rst.b_ready", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst.regwrite_held", 32'(rf_regwrite), 32'd0);
        reset = 1'b0;

        // B must wait a full STARVE_MAX again
        run_to_prio(n);
        chk("seq2.cycles_to_prio", 32'(n), 32'd4);
        chk("seq2.b_ready", 32'(b_ready), 32'd1);
        chk("seq2.a_ready", 32'(a_ready), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        #3;
        chk("seq2.regwrite", 32'(rf_regwrite), 32'd1);
        chk("seq2.writereg", 32'(rf_writereg), 32'd20);
        chk("seq2.writedata", rf_writedata, 32'h0000C0DE);
        chk("seq2.prio_b_after", 32'(prio_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
